operand_pairer: RTL and testbench

- Upstream feeder for the operand-pair compute stage.
- Accepts a serial stream of WIDTH-bit words with a valid/ready handshake.
- Groups consecutive words into (operand1, operand2) pairs and buffers up to two complete pairs.
- Presents pairs to the downstream compute/work stage over a valid/ready interface, giving full throughput (one pair per two input beats) under continuous flow.

---
 rtl/operand_pairer_pkg.sv | 14 +
 rtl/pair_fifo2.sv | 59 +++++
 rtl/operand_pairer.sv | 131 +++++++++++++
 tb/tb_operand_pairer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_pairer_pkg.sv
// Shared constants for the operand pairer: default widths, pair FIFO depth and
// the pairing FSM state encoding.
package operand_pairer_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } pair_state_t;

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry synchronous FIFO of operand pairs; head visible combinationally, zero when empty.
// Pushes while full and pops while empty are ignored; full/empty come from registered state.
module pair_fifo2
  import operand_pairer_pkg::*;
#(
  parameter int DW = 2 * DEF_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/operand_pairer.sv
// Groups a serial word stream into (op1, op2) pairs buffered two deep; a pair appears one cycle
// after its closing word, and s_ready_o drops only when both slots hold. Define OPERAND_PAIRER_COUNT_EN for pair_count_o.
module operand_pairer
  import operand_pairer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_op1_o,
  output logic [WIDTH-1:0] m_op2_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
`ifdef OPERAND_PAIRER_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] pair_count_o
`endif
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("operand_pairer: WIDTH and CNT_WIDTH must be at least 1");
  end

  pair_state_t        state;
  pair_state_t        state_nxt;
  logic [WIDTH-1:0]   hold;
  logic               hold_load;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [2*WIDTH-1:0] push_dat;
  logic [2*WIDTH-1:0] head_dat;

  // Ready depends only on reset and registered occupancy, never on m_ready_i.
  assign s_ready_o = !rst_i && !full;
  assign accept    = s_valid_i && s_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A: if (accept && !s_last_i) state_nxt = WAIT_B;
      WAIT_B: if (accept) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    hold_load = 1'b0;
    push_dat  = '0;
    case (state)
      WAIT_A: begin
        if (accept) begin
          if (s_last_i) begin
            push     = 1'b1;
            push_dat = {s_data_i, {WIDTH{1'b0}}};
          end else begin
            hold_load = 1'b1;
          end
        end
      end
      WAIT_B: begin
        if (accept) begin
          push     = 1'b1;
          push_dat = {hold, s_data_i};
        end
      end
      default: begin
        push      = 1'b0;
        hold_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold <= '0;
    end else if (hold_load) begin
      hold <= s_data_i;
    end
  end

  pair_fifo2 #(
    .DW(2 * WIDTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // Outputs are forced quiet during reset, even before the first reset edge clears the FIFO.
  assign m_valid_o = !rst_i && !empty;
  assign pop       = m_valid_o && m_ready_i;
  assign m_op1_o   = rst_i ? '0 : head_dat[2*WIDTH-1:WIDTH];
  assign m_op2_o   = rst_i ? '0 : head_dat[WIDTH-1:0];

`ifdef OPERAND_PAIRER_COUNT_EN
  logic [CNT_WIDTH-1:0] pair_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair_cnt <= '0;
    end else if (pop && (pair_cnt != {CNT_WIDTH{1'b1}})) begin
      pair_cnt <= pair_cnt + 1'b1;
    end
  end

  assign pair_count_o = rst_i ? '0 : pair_cnt;
`endif

endmodule

// File: tb/tb_operand_pairer.sv
// Directed bench for operand_pairer: reset, pairing, backpressure, odd last words,
// simultaneous push/pop, mid-pair reset and (when enabled) the saturating pair counter.
module tb_operand_pairer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_op1;
  logic [7:0] m_op2;
  logic       m_valid;
  logic       m_ready;
`ifdef OPERAND_PAIRER_COUNT_EN
  logic [1:0] pair_count;
  int         exp_cnt [5] = '{1, 2, 3, 3, 3};
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_pairer #(
    .WIDTH     (8),
    .CNT_WIDTH (2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_last_i  (s_last),
    .s_ready_o (s_ready),
    .m_op1_o   (m_op1),
    .m_op2_o   (m_op2),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
`ifdef OPERAND_PAIRER_COUNT_EN
    ,
    .pair_count_o (pair_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] o1, input logic [7:0] o2);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_op1"}, 32'(m_op1), 32'(o1));
    chk({tag, "_op2"}, 32'(m_op2), 32'(o2));
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  initial begin
    // Reset held three cycles with input traffic offered.
    rst = 1'b1;
    m_ready = 1'b0;
    drive(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_op1", 32'(m_op1), 32'd0);
`ifdef OPERAND_PAIRER_COUNT_EN
      chk("rst_count", 32'(pair_count), 32'd0);
`endif
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);

    // Basic pairing.
    m_ready = 1'b1;
    drive(1'b1, 8'h12, 1'b0);
    cyc();
    chk("basic_half_valid", 32'(m_valid), 32'd0);
    drive(1'b1, 8'h34, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("basic", 8'h12, 8'h34);
    cyc();
    chk("basic_one_cycle", 32'(m_valid), 32'd0);

    // Backpressure: two pairs fill the FIFO.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      #1;
      chk("bp_ready_before_full", 32'(s_ready), 32'd1);
      cyc();
    end
    drive(1'b1, 8'h05, 1'b0);
    chk("bp_full_ready", 32'(s_ready), 32'd0);
    chk_head("bp_head0", 8'h01, 8'h02);
    cyc();
    chk("bp_still_full", 32'(s_ready), 32'd0);
    chk_head("bp_stable", 8'h01, 8'h02);
    m_ready = 1'b1;
    cyc();
    chk_head("bp_head1", 8'h03, 8'h04);
    chk("bp_ready_again", 32'(s_ready), 32'd1);
    cyc();
    chk("bp_drained", 32'(m_valid), 32'd0);
    drive(1'b1, 8'h06, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("bp_head2", 8'h05, 8'h06);
    cyc();
    chk("bp_empty", 32'(m_valid), 32'd0);

    // Odd last word in WAIT_A pairs with zero.
    m_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("odd_a", 8'hAA, 8'h00);
    m_ready = 1'b1;
    cyc();
    chk("odd_a_popped", 32'(m_valid), 32'd0);

    // Last flag in WAIT_B completes a normal pair.
    m_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    cyc();
    drive(1'b1, 8'h22, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("odd_b", 8'h11, 8'h22);
    m_ready = 1'b1;
    cyc();
    chk("odd_b_popped", 32'(m_valid), 32'd0);

    // Push and pop in the same cycle with one entry buffered.
    m_ready = 1'b0;
    drive(1'b1, 8'h31, 1'b0);
    cyc();
    drive(1'b1, 8'h32, 1'b0);
    cyc();
    drive(1'b1, 8'h33, 1'b0);
    cyc();
    chk_head("pp_before", 8'h31, 8'h32);
    drive(1'b1, 8'h34, 1'b0);
    m_ready = 1'b1;
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("pp_after", 8'h33, 8'h34);
    cyc();
    chk("pp_empty", 32'(m_valid), 32'd0);

    // Reset in the middle of a pair discards the held word.
    drive(1'b1, 8'h55, 1'b0);
    cyc();
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b0);
    #1;
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    cyc();
    rst = 1'b0;
    drive(1'b1, 8'h66, 1'b0);
    chk("mid_rst_valid0", 32'(m_valid), 32'd0);
    cyc();
    chk("mid_rst_valid1", 32'(m_valid), 32'd0);
    drive(1'b1, 8'h77, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk_head("mid_rst_pair", 8'h66, 8'h77);
    cyc();
    chk("mid_rst_empty", 32'(m_valid), 32'd0);

    // Reset with a buffered pair discards it.
    m_ready = 1'b0;
    drive(1'b1, 8'h41, 1'b0);
    cyc();
    drive(1'b1, 8'h42, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    chk("buf_rst_before", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("buf_rst_gated", 32'(m_valid), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("buf_rst_after", 32'(m_valid), 32'd0);
    chk("buf_rst_ready", 32'(s_ready), 32'd1);

`ifdef OPERAND_PAIRER_COUNT_EN
    // Saturating pair counter.
    m_ready = 1'b1;
    chk("cnt_start", 32'(pair_count), 32'd0);
    for (int p = 0; p < 5; p++) begin
      drive(1'b1, 8'(2 * p), 1'b0);
      cyc();
      drive(1'b1, 8'(2 * p + 1), 1'b0);
      cyc();
      drive(1'b0, 8'h00, 1'b0);
      cyc();
      chk($sformatf("cnt_pair%0d", p), 32'(pair_count), 32'(exp_cnt[p]));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
